// File: rtl/branch_predictor_pkg.sv
// Shared core definitions for the fetch-stage branch predictor: opcodes,
// immediate layouts and instruction classification.
package branch_predictor_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;

  // Sign-replication widths of the B- and J-type immediates.
  localparam int BIMM_SIGN_W = 20;
  localparam int JIMM_SIGN_W = 12;

  typedef enum logic [1:0] {
    INSTR_OTHER = 2'd0,
    INSTR_BXX   = 2'd1,
    INSTR_JAL   = 2'd2
  } instr_class_e;

  function automatic instr_class_e classify(input logic [6:0] opcode);
    if (opcode == OPCODE_BRANCH) return INSTR_BXX;
    if (opcode == OPCODE_JAL)    return INSTR_JAL;
    return INSTR_OTHER;
  endfunction

  function automatic logic [XLEN-1:0] b_imm(input logic [31:0] instr);
    return {{BIMM_SIGN_W{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

  function automatic logic [XLEN-1:0] j_imm(input logic [31:0] instr);
    return {{JIMM_SIGN_W{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/branch_predictor_bht_table.sv
// Branch history table: an array of saturating up/down counters with one
// asynchronous read port and one synchronous update port.
module bht_table
  import branch_predictor_pkg::*;
#(
  parameter int BHT_DEPTH = 64,
  parameter int CNT_W     = 2,
  localparam int IDX_W    = $clog2(BHT_DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [CNT_W-1:0] rd_cnt_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic             wr_taken_i
);

  localparam logic [CNT_W-1:0] WEAK_NT = {1'b0, {(CNT_W-1){1'b1}}};

  logic [CNT_W-1:0] cnt_q [BHT_DEPTH];
  logic [CNT_W-1:0] wr_cnt_d;

  function automatic logic [CNT_W-1:0] sat_step(input logic [CNT_W-1:0] c,
                                                input logic up);
    if (up) return (&c) ? c : c + CNT_W'(1);
    return (c == '0) ? c : c - CNT_W'(1);
  endfunction

  assign rd_cnt_o = cnt_q[rd_idx_i];
  assign wr_cnt_d = sat_step(cnt_q[wr_idx_i], wr_taken_i);

  // Reset wins over a coincident update so the whole table restarts clean.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < BHT_DEPTH; i++) cnt_q[i] <= WEAK_NT;
    end else if (wr_en_i) begin
      cnt_q[wr_idx_i] <= wr_cnt_d;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage next-PC predictor: dynamic counter table or static
// backward-taken/forward-not-taken, plus a saturating misprediction counter.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int BHT_DEPTH = 64,
  parameter int CNT_W     = 2,
  parameter int USE_BHT   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  output logic [31:0] pre_pc,
  output logic        pre_taken,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic        upd_mispred,
  output logic [31:0] mispred_cnt
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  instr_class_e    cls;
  logic [XLEN-1:0] bimm;
  logic [XLEN-1:0] jimm;
  logic            cond_taken;
  logic [31:0]     mispred_cnt_q;
  logic [31:0]     mispred_cnt_d;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  assign cls  = classify(instr[6:0]);
  assign bimm = b_imm(instr);
  assign jimm = j_imm(instr);

  generate
    if (USE_BHT != 0) begin : g_bht
      logic [CNT_W-1:0] rd_cnt;
      logic [IDX_W-1:0] rd_idx;
      logic [IDX_W-1:0] wr_idx;
      logic             unused_upd;

      assign rd_idx = pc[IDX_W+1:2];
      assign wr_idx = upd_pc[IDX_W+1:2];

      bht_table #(
        .BHT_DEPTH (BHT_DEPTH),
        .CNT_W     (CNT_W)
      ) u_bht (
        .clk_i      (clk),
        .rst_i      (rst),
        .rd_idx_i   (rd_idx),
        .rd_cnt_o   (rd_cnt),
        .wr_en_i    (upd_valid),
        .wr_idx_i   (wr_idx),
        .wr_taken_i (upd_taken)
      );

      // No bypass: a same-cycle update to this entry is seen next cycle.
      assign cond_taken = rd_cnt[CNT_W-1];
      assign unused_upd = ^{upd_pc[31:IDX_W+2], upd_pc[1:0]};
    end else begin : g_static
      logic unused_upd;

      // Negative displacement means a backward branch, typically a loop.
      assign cond_taken = bimm[XLEN-1];
      assign unused_upd = ^{upd_taken, upd_pc};
    end
  endgenerate

  always_comb begin
    pre_taken = 1'b0;
    pre_pc    = pc + 32'd4;
    case (cls)
      INSTR_JAL: begin
        pre_taken = 1'b1;
        pre_pc    = pc + jimm;
      end
      INSTR_BXX: begin
        pre_taken = cond_taken;
        if (cond_taken) pre_pc = pc + bimm;
      end
      default: ;
    endcase
  end

  always_comb begin
    mispred_cnt_d = mispred_cnt_q;
    if (upd_valid && upd_mispred) mispred_cnt_d = sat_inc32(mispred_cnt_q);
  end

  always_ff @(posedge clk) begin
    if (rst) mispred_cnt_q <= '0;
    else     mispred_cnt_q <= mispred_cnt_d;
  end

  assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench: a dynamic-table and a static instance share stimulus;
// expectations come from an integer-array reference model.
module tb_branch_predictor;

  localparam int DEPTH = 64;
  localparam int CW    = 2;
  localparam int K_OTH = 0;
  localparam int K_B   = 1;
  localparam int K_J   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] instr = 32'h0000_0013;
  logic [31:0] pc = '0;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic        upd_mispred = 1'b0;
  logic [31:0] pre_pc_b, pre_pc_s, mis_b, mis_s;
  logic        pre_taken_b, pre_taken_s;

  always #5 clk = ~clk;

  branch_predictor #(.BHT_DEPTH(DEPTH), .CNT_W(CW), .USE_BHT(1)) dut_bht (
    .clk(clk), .rst(rst), .instr(instr), .pc(pc),
    .pre_pc(pre_pc_b), .pre_taken(pre_taken_b),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_mispred(upd_mispred), .mispred_cnt(mis_b)
  );

  branch_predictor #(.BHT_DEPTH(DEPTH), .CNT_W(CW), .USE_BHT(0)) dut_st (
    .clk(clk), .rst(rst), .instr(instr), .pc(pc),
    .pre_pc(pre_pc_s), .pre_taken(pre_taken_s),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_mispred(upd_mispred), .mispred_cnt(mis_s)
  );

  typedef struct {
    logic [31:0] pc_b;
    logic [31:0] pc_s;
    logic [31:0] mis;
    logic        tk_b;
    logic        tk_s;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;
  logic  obs_vld = 1'b0;

  int              model_cnt [DEPTH];
  longint unsigned model_mis = 0;

  task automatic chk32(input string nm, input string fld,
                       input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, req);
    end
  endtask

  exp_t  mon_e;
  string mon_n;
  always @(negedge clk) begin
    if (obs_vld) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty actual=0 required=1");
      end else begin
        mon_e = exp_q.pop_front();
        mon_n = name_q.pop_front();
        chk32(mon_n, "pre_pc_bht", pre_pc_b, mon_e.pc_b);
        chk32(mon_n, "pre_taken_bht", {31'd0, pre_taken_b}, {31'd0, mon_e.tk_b});
        chk32(mon_n, "pre_pc_static", pre_pc_s, mon_e.pc_s);
        chk32(mon_n, "pre_taken_static", {31'd0, pre_taken_s}, {31'd0, mon_e.tk_s});
        chk32(mon_n, "mispred_bht", mis_b, mon_e.mis);
        chk32(mon_n, "mispred_static", mis_s, mon_e.mis);
      end
    end
  end

  function automatic logic [31:0] enc_b(input int imm, input logic [31:0] rnd);
    logic [31:0] w;
    logic [12:0] b;
    b = imm[12:0];
    w = rnd;
    w[31] = b[12];
    w[30:25] = b[10:5];
    w[11:8] = b[4:1];
    w[7] = b[11];
    w[6:0] = 7'b1100011;
    return w;
  endfunction

  function automatic logic [31:0] enc_j(input int imm, input logic [31:0] rnd);
    logic [31:0] w;
    logic [20:0] j;
    j = imm[20:0];
    w = rnd;
    w[31] = j[20];
    w[30:21] = j[10:1];
    w[20] = j[11];
    w[19:12] = j[19:12];
    w[6:0] = 7'b1101111;
    return w;
  endfunction

  function automatic logic [31:0] enc_other(input logic [31:0] rnd);
    logic [6:0] ops [4];
    logic [31:0] w;
    ops[0] = 7'b0010011; ops[1] = 7'b0110011; ops[2] = 7'b0000011; ops[3] = 7'b1100111;
    w = rnd;
    w[6:0] = ops[rnd[1:0]];
    return w;
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  // One cycle: drive, record expectation from the model, clock, advance model.
  task automatic step(input string nm, input bit chk, input int kind, input int imm,
                      input logic [31:0] p, input logic uv, input logic [31:0] up,
                      input logic ut, input logic um, input logic r);
    exp_t e;
    logic [31:0] rnd;
    logic bt;
    rnd = $urandom();
    case (kind)
      K_B:     instr = enc_b(imm, rnd);
      K_J:     instr = enc_j(imm, rnd);
      default: instr = enc_other(rnd);
    endcase
    pc = p; upd_valid = uv; upd_pc = up; upd_taken = ut; upd_mispred = um; rst = r;
    e.pc_b = p + 32'd4; e.pc_s = p + 32'd4; e.tk_b = 1'b0; e.tk_s = 1'b0;
    e.mis = 32'(model_mis);
    if (kind == K_J) begin
      e.tk_b = 1'b1; e.tk_s = 1'b1;
      e.pc_b = p + 32'(imm); e.pc_s = p + 32'(imm);
    end else if (kind == K_B) begin
      bt = model_cnt[idx_of(p)] >= (1 << (CW - 1));
      e.tk_b = bt;
      e.tk_s = imm < 0;
      if (bt) e.pc_b = p + 32'(imm);
      if (imm < 0) e.pc_s = p + 32'(imm);
    end
    if (chk) begin
      exp_q.push_back(e);
      name_q.push_back(nm);
    end
    obs_vld = chk;
    @(posedge clk);
    #1;
    if (r) begin
      for (int i = 0; i < DEPTH; i++) model_cnt[i] = (1 << (CW - 1)) - 1;
      model_mis = 0;
    end else if (uv) begin
      if (ut) begin
        if (model_cnt[idx_of(up)] < (1 << CW) - 1) model_cnt[idx_of(up)]++;
      end else begin
        if (model_cnt[idx_of(up)] > 0) model_cnt[idx_of(up)]--;
      end
      if (um && model_mis < 64'hFFFF_FFFF) model_mis++;
    end
  endtask

  initial begin
    int kind, imm;
    logic [31:0] p, up;
    for (int i = 0; i < DEPTH; i++) model_cnt[i] = (1 << (CW - 1)) - 1;
    @(posedge clk);
    #1;
    step("rst0", 0, K_OTH, 0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    step("rst1", 0, K_OTH, 0, 32'h0, 1'b1, 32'h100, 1'b1, 1'b1, 1'b1);
    step("reset_state", 1, K_OTH, 0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    step("beq_weak_nt", 1, K_B, 16, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    step("upd_taken1", 1, K_OTH, 0, 32'h104, 1'b1, 32'h100, 1'b1, 1'b0, 1'b0);
    step("upd_taken2", 1, K_OTH, 0, 32'h108, 1'b1, 32'h100, 1'b1, 1'b0, 1'b0);
    step("beq_strong", 1, K_B, 16, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    step("upd_taken3", 1, K_OTH, 0, 32'h10C, 1'b1, 32'h100, 1'b1, 1'b0, 1'b0);
    step("beq_sat_hi", 1, K_B, 16, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    step("jal_back8", 1, K_J, -8, 32'h200, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    step("same_cyc1", 1, K_B, 16, 32'h100, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
    step("same_cyc2", 1, K_B, 16, 32'h100, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
    step("after_upd", 1, K_B, 16, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    step("alias_upd", 1, K_OTH, 0, 32'h110, 1'b1, 32'h100 + 4 * DEPTH, 1'b1, 1'b0, 1'b0);
    step("alias_rd", 1, K_B, 16, 32'h100 + 4 * DEPTH, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    step("beq_back12", 1, K_B, -12, 32'h300, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    step("beq_fwd20", 1, K_B, 20, 32'h300, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    step("mis1", 1, K_OTH, 0, 32'h400, 1'b1, 32'h400, 1'b0, 1'b1, 1'b0);
    step("mis2", 1, K_OTH, 0, 32'h404, 1'b1, 32'h404, 1'b1, 1'b1, 1'b0);
    step("mis3", 1, K_OTH, 0, 32'h408, 1'b1, 32'h408, 1'b0, 1'b1, 1'b0);
    step("mis_ignored", 1, K_OTH, 0, 32'h40C, 1'b0, 32'h100, 1'b1, 1'b1, 1'b0);
    step("rst_with_upd", 1, K_B, 16, 32'h100, 1'b1, 32'h100, 1'b1, 1'b1, 1'b1);
    step("post_rst", 1, K_B, 16, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 400; n++) begin
      kind = int'($urandom_range(0, 2));
      if (kind == K_B) imm = int'($urandom_range(0, 4095)) * 2 - 4096;
      else if (kind == K_J) imm = int'($urandom_range(0, (1 << 20) - 1)) * 2 - (1 << 20);
      else imm = 0;
      p  = 32'h1000 + {$urandom_range(0, 2 * DEPTH - 1), 2'b00};
      up = 32'h1000 + {$urandom_range(0, 2 * DEPTH - 1), 2'b00};
      step("random", 1, kind, imm, p, 1'($urandom_range(0, 1)), up,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 49) == 0));
    end
    obs_vld = 1'b0;
    upd_valid = 1'b0;
    @(negedge clk);
    chk32("drain", "pending", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
